// File: rtl/fpmul_sched_if.sv
// fpmul_sched_if: request port, per-core start/result lines and the shared tagged result bus
// of the fpmul_sched scheduler.
interface fpmul_sched_if #(
   parameter int unsigned SIZE = 32
);
   logic [SIZE-1:0] op1;
   logic [SIZE-1:0] op2;
   logic [1:0]      in_rdy;
   logic            in_ack;
   logic            busy;
   logic            u0_start;
   logic            u1_start;
   logic [SIZE-1:0] u0_op1;
   logic [SIZE-1:0] u0_op2;
   logic [SIZE-1:0] u1_op1;
   logic [SIZE-1:0] u1_op2;
   logic            u0_done;
   logic            u1_done;
   logic [SIZE-1:0] u0_res;
   logic [SIZE-1:0] u1_res;
   logic [SIZE-1:0] res;
   logic [1:0]      res_rdy;
   logic            res_ack;
   logic            err;

   modport slave (
      input  op1, op2, in_rdy, u0_done, u1_done, u0_res, u1_res, res_ack,
      output in_ack, busy, u0_start, u1_start, u0_op1, u0_op2, u1_op1, u1_op2,
             res, res_rdy, err
   );

   modport master (
      output op1, op2, in_rdy, u0_done, u1_done, u0_res, u1_res, res_ack,
      input  in_ack, busy, u0_start, u1_start, u0_op1, u0_op2, u1_op1, u1_op2,
             res, res_rdy, err
   );
endinterface

// File: rtl/fpmul_sched.sv
// fpmul_sched: starts the two shared FP multiplier cores and serializes their results onto one
// tagged result bus. Optional watchdog enabled by defining FPMUL_SCHED_TIMEOUT_EN.
module fpmul_sched #(
   parameter int unsigned SIZE    = 32,
   parameter int unsigned TIMEOUT = 64
) (
   input logic          clk,
   input logic          rst,
   fpmul_sched_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e          st_q, st_d;
   logic [SIZE-1:0] op1_q, op1_d, op2_q, op2_d;
   logic [SIZE-1:0] buf0_q, buf0_d, buf1_q, buf1_d, res_q, res_d;
   logic [1:0]      pend_q, pend_d, vld_q, vld_d, start_q, start_d, res_rdy_q, res_rdy_d;
   logic            in_ack_q, in_ack_d, last_q, last_d;
   logic [1:0]      cap, avail;
   logic            acked, grant1;

   if (TIMEOUT < 2) begin : g_timeout_check
      $error("fpmul_sched: TIMEOUT must be at least 2");
   end

`ifdef FPMUL_SCHED_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT);
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
`endif

   always_comb begin
      st_d      = st_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      in_ack_d  = 1'b0;
      start_d   = 2'b00;
      last_d    = last_q;
      res_d     = res_q;
      res_rdy_d = res_rdy_q;
      grant1    = 1'b0;
`ifdef FPMUL_SCHED_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_d     = err_q;
`endif
      cap    = {bus.u1_done & pend_q[1] & ~vld_q[1], bus.u0_done & pend_q[0] & ~vld_q[0]};
      buf0_d = cap[0] ? bus.u0_res : buf0_q;
      buf1_d = cap[1] ? bus.u1_res : buf1_q;
      pend_d = pend_q & ~cap;
      acked  = bus.res_ack & (res_rdy_q != 2'b00);
      avail  = (vld_q | cap) & ~(acked ? res_rdy_q : 2'b00);
      vld_d  = avail;

      // A result may be presented on its own capture edge, and an ack hands straight over to
      // the other buffer; the round-robin pointer only moves when both contend.
      if (res_rdy_q == 2'b00 || acked) begin
         if (avail == 2'b11) begin
            grant1 = ~last_q;
            last_d = grant1;
         end else begin
            grant1 = avail[1];
         end
         if (avail == 2'b00) begin
            res_rdy_d = 2'b00;
         end else begin
            res_rdy_d = grant1 ? 2'b10 : 2'b01;
            res_d     = grant1 ? buf1_d : buf0_d;
         end
      end

      unique case (st_q)
         StIdle: begin
            if (bus.in_rdy != 2'b00) begin
               op1_d    = bus.op1;
               op2_d    = bus.op2;
               pend_d   = bus.in_rdy;
               in_ack_d = 1'b1;
               start_d  = bus.in_rdy;
               st_d     = StRun;
`ifdef FPMUL_SCHED_TIMEOUT_EN
               cnt_d    = '0;
               err_d    = 1'b0;
`endif
            end
         end
         StRun: begin
            if (acked && pend_d == 2'b00 && avail == 2'b00) begin
               st_d = StIdle;
            end
`ifdef FPMUL_SCHED_TIMEOUT_EN
            if (pend_q != 2'b00) begin
               if (cnt_q == CntW'(TIMEOUT - 1)) begin
                  pend_d = 2'b00;
                  err_d  = 1'b1;
                  if (res_rdy_d == 2'b00) begin
                     st_d = StIdle;
                  end
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         st_q      <= StIdle;
         op1_q     <= '0;
         op2_q     <= '0;
         buf0_q    <= '0;
         buf1_q    <= '0;
         res_q     <= '0;
         pend_q    <= 2'b00;
         vld_q     <= 2'b00;
         start_q   <= 2'b00;
         res_rdy_q <= 2'b00;
         in_ack_q  <= 1'b0;
         last_q    <= 1'b1;
`ifdef FPMUL_SCHED_TIMEOUT_EN
         cnt_q     <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         st_q      <= st_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         buf0_q    <= buf0_d;
         buf1_q    <= buf1_d;
         res_q     <= res_d;
         pend_q    <= pend_d;
         vld_q     <= vld_d;
         start_q   <= start_d;
         res_rdy_q <= res_rdy_d;
         in_ack_q  <= in_ack_d;
         last_q    <= last_d;
`ifdef FPMUL_SCHED_TIMEOUT_EN
         cnt_q     <= cnt_d;
         err_q     <= err_d;
`endif
      end
   end

   assign bus.in_ack   = in_ack_q;
   assign bus.busy     = (st_q == StRun);
   assign bus.u0_start = start_q[0];
   assign bus.u1_start = start_q[1];
   assign bus.u0_op1   = op1_q;
   assign bus.u0_op2   = op2_q;
   assign bus.u1_op1   = op1_q;
   assign bus.u1_op2   = op2_q;
   assign bus.res      = res_q;
   assign bus.res_rdy  = res_rdy_q;
`ifdef FPMUL_SCHED_TIMEOUT_EN
   assign bus.err      = err_q;
`else
   assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_fpmul_sched.sv
// tb_fpmul_sched: directed stimulus for fpmul_sched with literal checks and a per-cycle
// behavioural model of the scheduler compared on every falling edge.
`timescale 1ns/1ps
module tb_fpmul_sched;
   localparam int unsigned SIZE    = 32;
   localparam int unsigned TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   cyc;

   fpmul_sched_if #(.SIZE(SIZE)) bus ();

   fpmul_sched #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Model state: which core is presented (-1 = none), buffered results, outstanding requests.
   logic        m_known = 1'b0;
   logic        m_busy, m_ack, m_err, m_acked, m_pend_any;
   logic [1:0]  m_start, m_pend, m_val, m_done;
   logic [31:0] m_op1, m_op2, m_res;
   logic [31:0] m_buf [2];
   logic [31:0] m_cres [2];
   int          m_pres, m_last, m_cnt;

   initial forever begin
      @(negedge clk);
      if (m_known) begin
         chk("m.in_ack", 32'(bus.in_ack), 32'(m_ack));
         chk("m.busy", 32'(bus.busy), 32'(m_busy));
         chk("m.start", 32'({bus.u1_start, bus.u0_start}), 32'(m_start));
         chk("m.u0_op1", bus.u0_op1, m_op1);
         chk("m.u0_op2", bus.u0_op2, m_op2);
         chk("m.u1_op1", bus.u1_op1, m_op1);
         chk("m.u1_op2", bus.u1_op2, m_op2);
         chk("m.res_rdy", 32'(bus.res_rdy), (m_pres < 0) ? 32'd0 : (32'd1 << m_pres));
         chk("m.res", bus.res, m_res);
         chk("m.err", 32'(bus.err), 32'(m_err));
      end
      if (rst !== 1'b1) begin
         m_known = 1'b1;
         m_busy  = 1'b0;
         m_ack   = 1'b0;
         m_err   = 1'b0;
         m_start = 2'b00;
         m_pend  = 2'b00;
         m_val   = 2'b00;
         m_op1   = '0;
         m_op2   = '0;
         m_res   = '0;
         m_buf[0] = '0;
         m_buf[1] = '0;
         m_pres  = -1;
         m_last  = 1;
         m_cnt   = 0;
      end else if (m_known) begin
         m_ack      = 1'b0;
         m_start    = 2'b00;
         m_done     = {bus.u1_done, bus.u0_done};
         m_cres[0]  = bus.u0_res;
         m_cres[1]  = bus.u1_res;
         m_pend_any = (m_pend != 2'b00);
         for (int c = 0; c < 2; c++) begin
            if (m_done[c] && m_pend[c] && !m_val[c]) begin
               m_buf[c]  = m_cres[c];
               m_val[c]  = 1'b1;
               m_pend[c] = 1'b0;
            end
         end
         if (!m_busy) begin
            if (bus.in_rdy != 2'b00) begin
               m_op1   = bus.op1;
               m_op2   = bus.op2;
               m_pend  = bus.in_rdy;
               m_ack   = 1'b1;
               m_start = bus.in_rdy;
               m_busy  = 1'b1;
               m_err   = 1'b0;
               m_cnt   = 0;
            end
         end else begin
            m_acked = bus.res_ack && (m_pres >= 0);
            if (m_acked) begin
               m_val[m_pres] = 1'b0;
               m_pres = -1;
            end
            if (m_pres < 0) begin
               if (m_val == 2'b11) begin
                  m_pres = 1 - m_last;
                  m_last = m_pres;
               end else if (m_val[0]) begin
                  m_pres = 0;
               end else if (m_val[1]) begin
                  m_pres = 1;
               end
               if (m_pres >= 0) m_res = m_buf[m_pres];
            end
            if (m_acked && m_pend == 2'b00 && m_val == 2'b00) m_busy = 1'b0;
`ifdef FPMUL_SCHED_TIMEOUT_EN
            if (m_pend_any) begin
               if (m_cnt == TIMEOUT - 1) begin
                  m_pend = 2'b00;
                  m_err  = 1'b1;
                  if (m_pres < 0) m_busy = 1'b0;
               end else begin
                  m_cnt++;
               end
            end
`endif
         end
      end
   end

   initial begin
      rst         = 1'b0;
      bus.op1     = '0;
      bus.op2     = '0;
      bus.in_rdy  = 2'b00;
      bus.u0_done = 1'b0;
      bus.u1_done = 1'b0;
      bus.u0_res  = '0;
      bus.u1_res  = '0;
      bus.res_ack = 1'b0;
      step(3);
      chk("rst.busy", 32'(bus.busy), 32'd0);
      chk("rst.res_rdy", 32'(bus.res_rdy), 32'd0);
      chk("rst.res", bus.res, 32'd0);
      chk("rst.in_ack", 32'(bus.in_ack), 32'd0);
      rst = 1'b1;
      step(1);

      // Single request to core 0, 3-cycle core latency.
      bus.op1    = 32'h4000_0000;
      bus.op2    = 32'h4000_0000;
      bus.in_rdy = 2'b01;
      step(1);
      bus.in_rdy = 2'b00;
      chk("t1.in_ack", 32'(bus.in_ack), 32'd1);
      chk("t1.u0_start", 32'(bus.u0_start), 32'd1);
      chk("t1.u1_start", 32'(bus.u1_start), 32'd0);
      chk("t1.busy", 32'(bus.busy), 32'd1);
      chk("t1.u0_op1", bus.u0_op1, 32'h4000_0000);
      step(3);
      chk("t1.no_early_rdy", 32'(bus.res_rdy), 32'd0);
      bus.u0_done = 1'b1;
      bus.u0_res  = 32'h4080_0000;
      step(1);
      bus.u0_done = 1'b0;
      chk("t1.res_rdy", 32'(bus.res_rdy), 32'h1);
      chk("t1.res", bus.res, 32'h4080_0000);
      bus.res_ack = 1'b1;
      step(1);
      bus.res_ack = 1'b0;
      chk("t1.busy_after_ack", 32'(bus.busy), 32'd0);
      chk("t1.rdy_after_ack", 32'(bus.res_rdy), 32'd0);
      chk("t1.res_held", bus.res, 32'h4080_0000);

      // Both cores, simultaneous dones, back-to-back hand-off, then round-robin on repeat.
      bus.op1    = 32'h3F80_0000;
      bus.op2    = 32'h3F80_0000;
      bus.in_rdy = 2'b11;
      step(1);
      bus.in_rdy = 2'b00;
      chk("t2.starts", 32'({bus.u1_start, bus.u0_start}), 32'h3);
      step(1);
      bus.u0_done = 1'b1;
      bus.u0_res  = 32'h3F80_0000;
      bus.u1_done = 1'b1;
      bus.u1_res  = 32'h3F80_0001;
      step(1);
      bus.u0_done = 1'b0;
      bus.u1_done = 1'b0;
      chk("t2.first_rdy", 32'(bus.res_rdy), 32'h1);
      chk("t2.first_res", bus.res, 32'h3F80_0000);
      bus.res_ack = 1'b1;
      step(1);
      chk("t2.second_rdy", 32'(bus.res_rdy), 32'h2);
      chk("t2.second_res", bus.res, 32'h3F80_0001);
      step(1);
      bus.res_ack = 1'b0;
      chk("t2.idle", 32'(bus.busy), 32'd0);
      bus.in_rdy = 2'b11;
      step(1);
      bus.in_rdy = 2'b00;
      step(1);
      bus.u0_done = 1'b1;
      bus.u0_res  = 32'h4040_0000;
      bus.u1_done = 1'b1;
      bus.u1_res  = 32'h40A0_0000;
      step(1);
      bus.u0_done = 1'b0;
      bus.u1_done = 1'b0;
      chk("t2.rr_first_rdy", 32'(bus.res_rdy), 32'h2);
      chk("t2.rr_first_res", bus.res, 32'h40A0_0000);
      bus.res_ack = 1'b1;
      step(1);
      chk("t2.rr_second_rdy", 32'(bus.res_rdy), 32'h1);
      chk("t2.rr_second_res", bus.res, 32'h4040_0000);
      step(1);
      bus.res_ack = 1'b0;
      chk("t2.rr_idle", 32'(bus.busy), 32'd0);

      // Core 1 finishes two cycles before core 0.
      bus.in_rdy = 2'b11;
      step(1);
      bus.in_rdy  = 2'b00;
      bus.u1_done = 1'b1;
      bus.u1_res  = 32'h4100_0000;
      step(1);
      bus.u1_done = 1'b0;
      chk("t3.first_rdy", 32'(bus.res_rdy), 32'h2);
      chk("t3.first_res", bus.res, 32'h4100_0000);
      step(1);
      bus.u0_done = 1'b1;
      bus.u0_res  = 32'h4110_0000;
      step(1);
      bus.u0_done = 1'b0;
      chk("t3.held_rdy", 32'(bus.res_rdy), 32'h2);
      chk("t3.held_res", bus.res, 32'h4100_0000);
      bus.res_ack = 1'b1;
      step(1);
      chk("t3.second_rdy", 32'(bus.res_rdy), 32'h1);
      chk("t3.second_res", bus.res, 32'h4110_0000);
      step(1);
      bus.res_ack = 1'b0;
      chk("t3.idle", 32'(bus.busy), 32'd0);

      // Stall without ack; request in RUN, duplicate and unrequested dones all ignored.
      bus.in_rdy = 2'b01;
      step(1);
      bus.in_rdy  = 2'b00;
      bus.u0_done = 1'b1;
      bus.u0_res  = 32'h4200_0000;
      step(1);
      bus.u0_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 2) bus.in_rdy = 2'b01;
         if (i == 4) begin
            bus.u0_done = 1'b1;
            bus.u0_res  = 32'hDEAD_BEEF;
            bus.u1_done = 1'b1;
            bus.u1_res  = 32'h1234_5678;
         end
         step(1);
         bus.in_rdy  = 2'b00;
         bus.u0_done = 1'b0;
         bus.u1_done = 1'b0;
         chk("t4.stable_rdy", 32'(bus.res_rdy), 32'h1);
         chk("t4.stable_res", bus.res, 32'h4200_0000);
         if (i == 2) chk("t4.no_ack_in_run", 32'(bus.in_ack), 32'd0);
      end
      bus.res_ack = 1'b1;
      step(1);
      bus.res_ack = 1'b0;
      chk("t4.idle", 32'(bus.busy), 32'd0);
      chk("t4.no_rdy", 32'(bus.res_rdy), 32'd0);

      // Core 1 never answers.
      bus.in_rdy = 2'b11;
      step(1);
      bus.in_rdy  = 2'b00;
      cyc         = 1;
      bus.u0_done = 1'b1;
      bus.u0_res  = 32'h4300_0000;
      step(1);
      bus.u0_done = 1'b0;
      cyc         = 2;
      chk("t5.core0_rdy", 32'(bus.res_rdy), 32'h1);
      chk("t5.core0_res", bus.res, 32'h4300_0000);
`ifdef FPMUL_SCHED_TIMEOUT_EN
      while (bus.err !== 1'b1 && cyc < 40) begin
         step(1);
         cyc++;
      end
      chk("t5.err_cycle", cyc, 32'd17);
      chk("t5.still_busy", 32'(bus.busy), 32'd1);
      bus.res_ack = 1'b1;
      step(1);
      bus.res_ack = 1'b0;
      chk("t5.idle_after_ack", 32'(bus.busy), 32'd0);
      chk("t5.err_sticky", 32'(bus.err), 32'd1);
`else
      step(30);
      chk("t5.busy_forever", 32'(bus.busy), 32'd1);
      chk("t5.no_err", 32'(bus.err), 32'd0);
      bus.res_ack = 1'b1;
      step(1);
      bus.res_ack = 1'b0;
      chk("t5.busy_pending", 32'(bus.busy), 32'd1);
      chk("t5.rdy_cleared", 32'(bus.res_rdy), 32'd0);
`endif

      // Reset mid-RUN, then a late done must not surface.
      bus.op1    = 32'h4400_0000;
      bus.in_rdy = 2'b01;
      step(1);
      bus.in_rdy = 2'b00;
      step(1);
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      chk("t6.busy", 32'(bus.busy), 32'd0);
      chk("t6.in_ack", 32'(bus.in_ack), 32'd0);
      chk("t6.start", 32'({bus.u1_start, bus.u0_start}), 32'd0);
      chk("t6.res_rdy", 32'(bus.res_rdy), 32'd0);
      chk("t6.res", bus.res, 32'd0);
      chk("t6.u0_op1", bus.u0_op1, 32'd0);
      chk("t6.err", 32'(bus.err), 32'd0);
      bus.u0_done = 1'b1;
      bus.u0_res  = 32'h4500_0000;
      step(1);
      bus.u0_done = 1'b0;
      chk("t6.late_done_rdy", 32'(bus.res_rdy), 32'd0);
      chk("t6.late_done_busy", 32'(bus.busy), 32'd0);
      step(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
